// File: rtl/bp_stream_pump_out.sv
// Transmit-side stream pump: turns a base header plus per-word FSM data into a
// multi-beat BedRock mem stream (critical word first, lock held until the last beat).
// Header layout, LSB first: msg_type[3:0], addr[paddr], size[2:0], lce_id, way_id.
module bp_stream_pump_out #(
    parameter int          paddr_width_p       = 40,
    parameter int          lce_id_width_p      = 4,
    parameter int          lce_assoc_p         = 8,
    parameter int          stream_data_width_p = 64,
    parameter int          block_width_p       = 512,
    parameter logic [15:0] payload_mask_p      = '0,
    localparam int mem_header_width_lp = 4 + paddr_width_p + 3 + lce_id_width_p + $clog2(lce_assoc_p),
    localparam int stream_words_lp     = block_width_p / stream_data_width_p,
    localparam int cnt_width_lp        = $clog2(stream_words_lp)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    input  logic [mem_header_width_lp-1:0] fsm_base_header_i,
    input  logic [stream_data_width_p-1:0] fsm_data_i,
    input  logic                           fsm_v_i,
    output logic                           fsm_ready_and_o,
    output logic [cnt_width_lp-1:0]        fsm_cnt_o,
    output logic                           fsm_new_o,
    output logic                           fsm_done_o,

    output logic [mem_header_width_lp-1:0] mem_header_o,
    output logic [stream_data_width_p-1:0] mem_data_o,
    output logic                           mem_v_o,
    output logic                           mem_lock_o,
    input  logic                           mem_ready_and_i
);

    localparam int data_bytes_lp   = stream_data_width_p / 8;
    localparam int offset_width_lp = $clog2(data_bytes_lp);
    localparam int entry_width_lp  = 1 + mem_header_width_lp + stream_data_width_p;

    typedef enum logic {
        e_ready,
        e_stream
    } state_e;

    state_e                    state_r, state_n;
    logic [cnt_width_lp-1:0]   cnt_r, cnt_n;
    logic [3:0]                msg_type;
    logic [2:0]                size;
    logic [cnt_width_lp-1:0]   first;
    logic [cnt_width_lp-1:0]   wrap_mask;
    logic [cnt_width_lp-1:0]   beat_idx;
    logic                      push_lock;
    logic                      accept;
    logic                      pop;

    logic [entry_width_lp-1:0] fifo_mem [2];
    logic                      wptr_r;
    logic                      rptr_r;
    logic [1:0]                count_r;
    logic                      full;

    assign msg_type = fsm_base_header_i[3:0];
    assign size     = fsm_base_header_i[4+paddr_width_p +: 3];
    assign first    = fsm_base_header_i[4+offset_width_lp +: cnt_width_lp];

    // wrap_mask = num-1; bit i is set when the message spans more than 2^i words,
    // which also clamps oversized requests to one cache block.
    always_comb begin
        wrap_mask = '0;
        if (payload_mask_p[msg_type]) begin
            for (int i = 0; i < cnt_width_lp; i++) begin
                if (int'(size) > offset_width_lp + i) begin
                    wrap_mask[i] = 1'b1;
                end
            end
        end
    end

    assign beat_idx = (first & ~wrap_mask) | ((first + cnt_r) & wrap_mask);

    assign full            = (count_r == 2'd2);
    assign fsm_ready_and_o = ~full & reset_n_i;
    assign accept          = fsm_v_i & fsm_ready_and_o;
    assign mem_v_o         = (count_r != 2'd0);
    assign pop             = mem_v_o & mem_ready_and_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_ready;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        fsm_cnt_o  = first;
        fsm_new_o  = 1'b0;
        fsm_done_o = 1'b0;
        push_lock  = 1'b0;
        case (state_r)
            e_ready: begin
                fsm_cnt_o = first;
                if (accept) begin
                    fsm_new_o = 1'b1;
                    if (wrap_mask == '0) begin
                        fsm_done_o = 1'b1;
                    end else begin
                        push_lock = 1'b1;
                        cnt_n     = cnt_width_lp'(1);
                        state_n   = e_stream;
                    end
                end
            end
            e_stream: begin
                fsm_cnt_o = beat_idx;
                if (accept) begin
                    if (cnt_r == wrap_mask) begin
                        fsm_done_o = 1'b1;
                        cnt_n      = '0;
                        state_n    = e_ready;
                    end else begin
                        push_lock = 1'b1;
                        cnt_n     = cnt_r + cnt_width_lp'(1);
                    end
                end
            end
            default: begin
                state_n = e_ready;
                cnt_n   = '0;
            end
        endcase
    end

    // Two-entry skid buffer decouples the FSM from bus backpressure at full rate.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= 1'b0;
            rptr_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (accept) begin
                wptr_r <= ~wptr_r;
            end
            if (pop) begin
                rptr_r <= ~rptr_r;
            end
            case ({accept, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_mem[wptr_r] <= {push_lock, fsm_base_header_i, fsm_data_i};
        end
    end

    assign {mem_lock_o, mem_header_o, mem_data_o} = fifo_mem[rptr_r];

endmodule

// File: tb/tb_bp_stream_pump_out.sv
// Randomized scoreboard bench for bp_stream_pump_out: driver pushes expected bus beats,
// a bus-side monitor pops and compares them.
module tb_bp_stream_pump_out;

    localparam int          paddr_width_p       = 40;
    localparam int          lce_id_width_p      = 4;
    localparam int          lce_assoc_p         = 8;
    localparam int          stream_data_width_p = 64;
    localparam int          block_width_p       = 512;
    localparam logic [15:0] payload_mask_p      = 16'h000A;
    localparam int          hdr_w   = 4 + paddr_width_p + 3 + lce_id_width_p + $clog2(lce_assoc_p);
    localparam int          entry_w = 1 + hdr_w + stream_data_width_p;

    localparam logic [3:0] t_rd    = 4'd0;
    localparam logic [3:0] t_wr    = 4'd1;
    localparam logic [3:0] t_uc_rd = 4'd2;
    localparam logic [3:0] t_uc_wr = 4'd3;

    logic                           clk = 1'b0;
    logic                           reset_n_i;
    logic [hdr_w-1:0]               fsm_base_header_i;
    logic [stream_data_width_p-1:0] fsm_data_i;
    logic                           fsm_v_i;
    logic                           fsm_ready_and_o;
    logic [2:0]                     fsm_cnt_o;
    logic                           fsm_new_o;
    logic                           fsm_done_o;
    logic [hdr_w-1:0]               mem_header_o;
    logic [stream_data_width_p-1:0] mem_data_o;
    logic                           mem_v_o;
    logic                           mem_lock_o;
    logic                           mem_ready_and_i = 1'b1;

    logic [entry_w-1:0] exp_q [$];
    int n_checks = 0;
    int n_fail = 0;
    int stall_left = 0;
    int ready_mode = 0;
    bit saw_not_ready = 0;

    bp_stream_pump_out #(
        .paddr_width_p      (paddr_width_p),
        .lce_id_width_p     (lce_id_width_p),
        .lce_assoc_p        (lce_assoc_p),
        .stream_data_width_p(stream_data_width_p),
        .block_width_p      (block_width_p),
        .payload_mask_p     (payload_mask_p)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n_i),
        .fsm_base_header_i(fsm_base_header_i),
        .fsm_data_i       (fsm_data_i),
        .fsm_v_i          (fsm_v_i),
        .fsm_ready_and_o  (fsm_ready_and_o),
        .fsm_cnt_o        (fsm_cnt_o),
        .fsm_new_o        (fsm_new_o),
        .fsm_done_o       (fsm_done_o),
        .mem_header_o     (mem_header_o),
        .mem_data_o       (mem_data_o),
        .mem_v_o          (mem_v_o),
        .mem_lock_o       (mem_lock_o),
        .mem_ready_and_i  (mem_ready_and_i)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [hdr_w-1:0] make_header(input logic [3:0] t, input logic [39:0] addr,
                                                     input logic [2:0] size, input logic [6:0] src);
        return {src, size, addr, t};
    endfunction

    // Beats per message: payload messages cover their size in 8-byte words, capped at one block.
    function automatic int model_num(input logic [3:0] t, input logic [2:0] size);
        int n;
        if (!payload_mask_p[t]) return 1;
        n = (1 << size) / (stream_data_width_p / 8);
        if (n < 1) n = 1;
        if (n > block_width_p / stream_data_width_p) n = block_width_p / stream_data_width_p;
        return n;
    endfunction

    function automatic int model_index(input int first, input int num, input int k);
        return (first / num) * num + (first + k) % num;
    endfunction

    // Bus-side ready generator; updates after the driver so a requested stall applies immediately.
    always @(posedge clk) begin
        #2;
        if (stall_left > 0) begin
            mem_ready_and_i = 1'b0;
            stall_left--;
        end else if (ready_mode == 0) begin
            mem_ready_and_i = 1'b1;
        end else begin
            mem_ready_and_i = ($urandom_range(99) < 70);
        end
    end

    always @(negedge clk) begin
        if (reset_n_i && mem_v_o && mem_ready_and_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_beat: got beat with lock=%0b, expected none", mem_lock_o);
            end else begin
                check_output("bus_beat", {mem_lock_o, mem_header_o, mem_data_o}, exp_q.pop_front());
            end
        end
    end

    task automatic apply_stimulus(input logic [3:0] t, input logic [39:0] addr, input logic [2:0] size,
                                  input int gap_pct, input int stall_after, input int reset_after);
        logic [hdr_w-1:0]               hdr;
        logic [stream_data_width_p-1:0] data;
        int num, first, idx, waited;
        hdr = make_header(t, addr, size, 7'($urandom));
        num = model_num(t, size);
        first = int'(addr[5:3]);
        fsm_base_header_i = hdr;
        for (int k = 0; k < num; k++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
                fsm_v_i = 1'b0;
                @(posedge clk);
                #1;
            end
            data = {$urandom, $urandom};
            fsm_v_i = 1'b1;
            fsm_data_i = data;
            waited = 0;
            @(negedge clk);
            while (!fsm_ready_and_o) begin
                saw_not_ready = 1;
                check_output("new_while_stalled", fsm_new_o, 0);
                check_output("done_while_stalled", fsm_done_o, 0);
                waited++;
                if (waited > 200) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL accept_timeout: got ready=0 for 200 cycles, expected ready=1");
                    fsm_v_i = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            idx = model_index(first, num, k);
            check_output("fsm_cnt", fsm_cnt_o, idx);
            check_output("fsm_new", fsm_new_o, (k == 0));
            check_output("fsm_done", fsm_done_o, (k == num - 1));
            exp_q.push_back({(k != num - 1), hdr, data});
            @(posedge clk);
            #1;
            if (k == stall_after) stall_left = 5;
            if (k == reset_after) begin
                reset_n_i = 1'b0;
                fsm_v_i = 1'b0;
                #1;
                check_output("reset_mem_v", mem_v_o, 0);
                check_output("reset_ready", fsm_ready_and_o, 0);
                exp_q.delete();
                @(negedge clk);
                reset_n_i = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
        end
        fsm_v_i = 1'b0;
    endtask

    initial begin
        int waited;
        reset_n_i = 1'b0;
        fsm_v_i = 1'b0;
        fsm_data_i = '0;
        fsm_base_header_i = make_header(t_uc_wr, 40'h1008, 3'd3, 7'd0);
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_mem_v", mem_v_o, 0);
        check_output("rst_ready", fsm_ready_and_o, 0);
        check_output("rst_new", fsm_new_o, 0);
        check_output("rst_done", fsm_done_o, 0);
        check_output("rst_cnt", fsm_cnt_o, 1);
        @(negedge clk);
        reset_n_i = 1'b1;
        @(posedge clk);
        #1;

        apply_stimulus(t_uc_wr, 40'h1008, 3'd3, 0, -1, -1);
        saw_not_ready = 0;
        apply_stimulus(t_wr, 40'h1018, 3'd6, 0, -1, -1);
        check_output("full_rate_no_stall", saw_not_ready, 0);
        apply_stimulus(t_rd, 40'h2000, 3'd6, 0, -1, -1);
        apply_stimulus(t_wr, 40'h1038, 3'd4, 0, -1, -1);
        saw_not_ready = 0;
        apply_stimulus(t_wr, 40'h3010, 3'd6, 0, 2, -1);
        check_output("backpressure_seen", saw_not_ready, 1);
        apply_stimulus(t_wr, 40'h4028, 3'd6, 0, -1, 3);
        apply_stimulus(t_uc_wr, 40'h2008, 3'd3, 0, -1, -1);

        ready_mode = 1;
        for (int m = 0; m < 60; m++) begin
            logic [3:0]  t;
            logic [39:0] addr;
            t = 4'($urandom_range(3));
            addr = {8'h00, $urandom};
            apply_stimulus(t, addr, 3'($urandom_range(6)), 30, -1, -1);
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            @(posedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        check_output("drain_empty", exp_q.size(), 0);
        check_output("drain_mem_v", mem_v_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
